// File: rtl/seq_serializer.sv
// -----------------------------------------------------------------------------
// seq_serializer
//   Parallel-to-serial converter. It accepts a WIDTH-bit word through a
//   load/ready handshake and shifts it out one bit per clock cycle, in
//   MSB-first or LSB-first order. When the next word is offered during the
//   final bit of the current word, the stream continues with no gap.
//
// Parameters
//   WIDTH     : parallel word width in bits (2..32)
//   MSB_FIRST : 1 = shift din[WIDTH-1] out first, 0 = shift din[0] out first
//
// Ports
//   clk       : in  - single clock; all state updates on its rising edge
//   reset     : in  - asynchronous reset, active low
//   din       : in  - parallel word, sampled only at the accepting edge
//   load      : in  - word-valid request
//   ready     : out - a load is accepted at the next rising edge
//   out       : out - serial bit stream (0 while idle)
//   out_valid : out - out carries a data bit
//   last      : out - out carries the final bit of the current word
//   dbg_state : out - FSM state for observation (0 = IDLE, 1 = SHIFT)
//
// Handshake: a word transfers at a rising edge where load=1 and ready=1.
//   ready is high in IDLE and during the last bit of a word; load while
//   ready=0 is dropped, never queued. load may go high or low at any time
//   and need not be held.
// -----------------------------------------------------------------------------
module seq_serializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             load,
  output logic             ready,
  output logic             out,
  output logic             out_valid,
  output logic             last,
  output logic             dbg_state
);

  localparam int             CW      = $clog2(WIDTH);
  localparam logic [CW-1:0]  CNT_TOP = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             accept;

  // State register, shift register and bit counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic and outputs.
  always_comb begin
    state_d   = state_q;
    sr_d      = sr_q;
    cnt_d     = cnt_q;
    ready     = 1'b0;
    accept    = 1'b0;
    out       = 1'b0;
    out_valid = 1'b0;
    last      = 1'b0;
    dbg_state = state_q;

    // The last bit cycle doubles as an acceptance slot, which is what makes
    // back-to-back words gapless.
    ready  = (state_q == IDLE) || (cnt_q == '0);
    accept = load && ready;

    if (accept) begin
      sr_d    = din;
      cnt_d   = CNT_TOP;
      state_d = SHIFT;
    end else if (state_q == SHIFT) begin
      if (cnt_q != '0) begin
        if (MSB_FIRST) begin
          sr_d = {sr_q[WIDTH-2:0], 1'b0};
        end else begin
          sr_d = {1'b0, sr_q[WIDTH-1:1]};
        end
        cnt_d = cnt_q - CW'(1);
      end else begin
        // Word finished with nothing queued: clear so no stale bits linger.
        sr_d    = '0;
        state_d = IDLE;
      end
    end

    // Outputs depend on registered state only; load and din never reach them.
    out_valid = (state_q == SHIFT);
    last      = (state_q == SHIFT) && (cnt_q == '0);
    if (state_q == SHIFT) begin
      out = MSB_FIRST ? sr_q[WIDTH-1] : sr_q[0];
    end
  end

endmodule
